// File: rtl/program_counter.sv
// Program counter with conditional jump/call and a small hardware return-address stack.
// Every output is a register that updates only on clk_en edges; rst takes precedence over everything.
module program_counter #(
    parameter int ADDR_WIDTH  = 16,
    parameter int STACK_DEPTH = 4,
    parameter int DEPTH_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_en,
    input  logic                   i_inc,
    input  logic                   i_jump,
    input  logic                   i_call,
    input  logic                   i_ret,
    input  logic [2:0]             i_cond,
    input  logic [ADDR_WIDTH-1:0]  i_target,
    input  logic                   i_zero,
    input  logic                   i_carry,
    input  logic                   i_odd,
    output logic [ADDR_WIDTH-1:0]  o_pc,
    output logic                   o_taken,
    output logic [DEPTH_WIDTH-1:0] o_depth,
    output logic                   o_overflow,
    output logic                   o_underflow
);

    logic [ADDR_WIDTH-1:0]  r_pc;
    logic                   r_taken;
    logic [DEPTH_WIDTH-1:0] r_depth;
    logic                   r_overflow;
    logic                   r_underflow;
    logic [ADDR_WIDTH-1:0]  r_stack [STACK_DEPTH];

    logic                   w_cond_true;
    logic [ADDR_WIDTH-1:0]  w_pc_inc;
    logic [ADDR_WIDTH-1:0]  w_top;
    logic                   w_push;
    logic [ADDR_WIDTH-1:0]  w_pc_next;
    logic                   w_taken_next;
    logic [DEPTH_WIDTH-1:0] w_depth_next;
    logic                   w_overflow_next;
    logic                   w_underflow_next;

    assign w_pc_inc = r_pc + {{(ADDR_WIDTH-1){1'b0}}, i_inc};

    // Condition decode from the flag values present at this edge
    always_comb begin
        w_cond_true = 1'b0;
        case (i_cond)
            3'd0:    w_cond_true = 1'b1;
            3'd1:    w_cond_true = i_zero;
            3'd2:    w_cond_true = ~i_zero;
            3'd3:    w_cond_true = i_carry;
            3'd4:    w_cond_true = ~i_carry;
            3'd5:    w_cond_true = i_odd;
            3'd6:    w_cond_true = ~i_odd;
            3'd7:    w_cond_true = 1'b0;
            default: w_cond_true = 1'b0;
        endcase
    end

    // Top-of-stack read: the entry just below the current depth
    always_comb begin
        w_top = {ADDR_WIDTH{1'b0}};
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (r_depth == DEPTH_WIDTH'(i + 1)) begin
                w_top = r_stack[i];
            end else begin
                w_top = w_top;
            end
        end
    end

    // Next-state decision; RET outranks CALL, which outranks JUMP
    always_comb begin
        w_pc_next        = w_pc_inc;
        w_taken_next     = 1'b0;
        w_depth_next     = r_depth;
        w_overflow_next  = r_overflow;
        w_underflow_next = r_underflow;
        w_push           = 1'b0;
        if (i_ret) begin
            if (r_depth != {DEPTH_WIDTH{1'b0}}) begin
                w_pc_next    = w_top;
                w_depth_next = r_depth - {{(DEPTH_WIDTH-1){1'b0}}, 1'b1};
                w_taken_next = 1'b1;
            end else begin
                w_underflow_next = 1'b1;
            end
        end else if (i_call) begin
            if (w_cond_true && (r_depth < DEPTH_WIDTH'(STACK_DEPTH))) begin
                w_push       = 1'b1;
                w_pc_next    = i_target;
                w_depth_next = r_depth + {{(DEPTH_WIDTH-1){1'b0}}, 1'b1};
                w_taken_next = 1'b1;
            end else if (w_cond_true) begin
                w_overflow_next = 1'b1;
            end else begin
                w_push = 1'b0;
            end
        end else if (i_jump) begin
            if (w_cond_true) begin
                w_pc_next    = i_target;
                w_taken_next = 1'b1;
            end else begin
                w_taken_next = 1'b0;
            end
        end else begin
            w_taken_next = 1'b0;
        end
    end

    // Architectural state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= {ADDR_WIDTH{1'b0}};
            r_taken     <= 1'b0;
            r_depth     <= {DEPTH_WIDTH{1'b0}};
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clk_en) begin
            r_pc        <= w_pc_next;
            r_taken     <= w_taken_next;
            r_depth     <= w_depth_next;
            r_overflow  <= w_overflow_next;
            r_underflow <= w_underflow_next;
        end else begin
            r_pc        <= r_pc;
            r_taken     <= r_taken;
            r_depth     <= r_depth;
            r_overflow  <= r_overflow;
            r_underflow <= r_underflow;
        end
    end

    // Return-address storage; a push writes the slot at the current depth
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (!rst && clk_en && w_push && (r_depth == DEPTH_WIDTH'(i))) begin
                r_stack[i] <= r_pc;
            end else begin
                r_stack[i] <= r_stack[i];
            end
        end
    end

    assign o_pc        = r_pc;
    assign o_taken     = r_taken;
    assign o_depth     = r_depth;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench: directed scenarios plus random stimulus against a
// queue-based reference model of the PC / return-stack behaviour.
module tb_program_counter;

    localparam int AW = 16;
    localparam int SD = 4;
    localparam int DW = 3;

    logic          clk;
    logic          rst;
    logic          clk_en;
    logic          i_inc;
    logic          i_jump;
    logic          i_call;
    logic          i_ret;
    logic [2:0]    i_cond;
    logic [AW-1:0] i_target;
    logic          i_zero;
    logic          i_carry;
    logic          i_odd;
    logic [AW-1:0] o_pc;
    logic          o_taken;
    logic [DW-1:0] o_depth;
    logic          o_overflow;
    logic          o_underflow;

    program_counter #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD), .DEPTH_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .i_inc(i_inc), .i_jump(i_jump), .i_call(i_call), .i_ret(i_ret),
        .i_cond(i_cond), .i_target(i_target),
        .i_zero(i_zero), .i_carry(i_carry), .i_odd(i_odd),
        .o_pc(o_pc), .o_taken(o_taken), .o_depth(o_depth),
        .o_overflow(o_overflow), .o_underflow(o_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [AW-1:0] m_pc;
    logic          m_taken;
    logic          m_ovf;
    logic          m_unf;
    logic [AW-1:0] m_stack [$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic model_step();
        logic [7:0] cond_tbl;
        logic       c;
        cond_tbl = {1'b0, ~i_odd, i_odd, ~i_carry, i_carry, ~i_zero, i_zero, 1'b1};
        c = cond_tbl[i_cond];
        if (rst) begin
            m_pc = '0; m_taken = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
            m_stack.delete();
        end else if (clk_en) begin
            m_taken = 1'b0;
            if (i_ret) begin
                if (m_stack.size() > 0) begin
                    m_pc = m_stack.pop_back();
                    m_taken = 1'b1;
                end else begin
                    m_pc = m_pc + AW'(i_inc);
                    m_unf = 1'b1;
                end
            end else if (i_call && c) begin
                if (m_stack.size() < SD) begin
                    m_stack.push_back(m_pc);
                    m_pc = i_target;
                    m_taken = 1'b1;
                end else begin
                    m_pc = m_pc + AW'(i_inc);
                    m_ovf = 1'b1;
                end
            end else if (i_jump && !i_call && c) begin
                m_pc = i_target;
                m_taken = 1'b1;
            end else begin
                m_pc = m_pc + AW'(i_inc);
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_value("pc", 32'(o_pc), 32'(m_pc));
        check_value("taken", 32'(o_taken), 32'(m_taken));
        check_value("depth", 32'(o_depth), 32'(m_stack.size()));
        check_value("overflow", 32'(o_overflow), 32'(m_ovf));
        check_value("underflow", 32'(o_underflow), 32'(m_unf));
    endtask

    task automatic idle();
        rst = 1'b0; clk_en = 1'b1; i_inc = 1'b1;
        i_jump = 1'b0; i_call = 1'b0; i_ret = 1'b0;
        i_cond = 3'd0; i_target = '0;
        i_zero = 1'b0; i_carry = 1'b0; i_odd = 1'b0;
    endtask

    task automatic do_jump(input logic [AW-1:0] t);
        idle(); i_jump = 1'b1; i_target = t; tick();
    endtask

    task automatic do_call(input logic [AW-1:0] t);
        idle(); i_call = 1'b1; i_target = t; tick();
    endtask

    task automatic do_ret();
        idle(); i_ret = 1'b1; tick();
    endtask

    initial begin
        m_pc = '0; m_taken = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        idle();
        rst = 1'b1;
        tick();
        check_value("reset_pc", 32'(o_pc), 32'h0);

        // Plain increment from reset
        idle();
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_value("inc_pc", 32'(o_pc), 32'(k));
        end

        // Wrap at all-ones
        do_jump(16'hFFFF);
        idle(); tick();
        check_value("wrap_pc", 32'(o_pc), 32'h0);
        check_value("wrap_taken", 32'(o_taken), 32'h0);

        // Conditional jump on Z, false then true
        do_jump(16'd7);
        idle(); i_jump = 1'b1; i_cond = 3'd1; i_target = 16'h0040; i_zero = 1'b0; tick();
        check_value("jz_false_pc", 32'(o_pc), 32'h8);
        idle(); i_jump = 1'b1; i_cond = 3'd1; i_target = 16'h0040; i_zero = 1'b1; tick();
        check_value("jz_true_pc", 32'(o_pc), 32'h40);
        check_value("jz_true_taken", 32'(o_taken), 32'h1);
        idle(); tick();
        check_value("taken_pulse", 32'(o_taken), 32'h0);

        // Nested calls and returns
        do_jump(16'd10);
        do_call(16'h0100);
        do_call(16'h0200);
        check_value("nest_depth", 32'(o_depth), 32'h2);
        do_ret();
        check_value("ret1_pc", 32'(o_pc), 32'h100);
        do_ret();
        check_value("ret2_pc", 32'(o_pc), 32'hA);
        check_value("ret2_depth", 32'(o_depth), 32'h0);

        // Overflow on fifth call, underflow on fifth return
        for (int k = 0; k < 4; k++) do_call(AW'(16'h0300 + k));
        do_call(16'h0400);
        check_value("ovf_pc", 32'(o_pc), 32'h304);
        check_value("ovf_depth", 32'(o_depth), 32'h4);
        check_value("ovf_flag", 32'(o_overflow), 32'h1);
        for (int k = 0; k < 5; k++) do_ret();
        check_value("unf_flag", 32'(o_underflow), 32'h1);
        check_value("unf_depth", 32'(o_depth), 32'h0);
        check_value("ovf_sticky", 32'(o_overflow), 32'h1);

        // RET beats CALL and JUMP
        do_jump(16'h0033);
        do_call(16'h0500);
        idle(); i_ret = 1'b1; i_call = 1'b1; i_jump = 1'b1; i_target = 16'h0777; tick();
        check_value("prio_pc", 32'(o_pc), 32'h33);
        check_value("prio_depth", 32'(o_depth), 32'h0);
        idle(); clk_en = 1'b0; tick();
        check_value("hold_pc", 32'(o_pc), 32'h33);
        check_value("hold_taken", 32'(o_taken), 32'h1);

        // Reset overrides a disabled clock and a pending call
        do_call(16'h0601); do_call(16'h0602); do_call(16'h0603);
        idle(); rst = 1'b1; clk_en = 1'b0; tick();
        check_value("rst_pc", 32'(o_pc), 32'h0);
        check_value("rst_ovf", 32'(o_overflow), 32'h0);
        idle(); rst = 1'b1; i_call = 1'b1; i_target = 16'h0999; tick();
        check_value("rst_call_depth", 32'(o_depth), 32'h0);

        // Random stimulus
        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(0, 99) == 0);
            clk_en   = ($urandom_range(0, 3) != 0);
            i_inc    = 1'($urandom);
            i_ret    = ($urandom_range(0, 4) == 0);
            i_call   = ($urandom_range(0, 3) == 0);
            i_jump   = ($urandom_range(0, 3) == 0);
            i_cond   = 3'($urandom);
            i_target = AW'($urandom);
            i_zero   = 1'($urandom);
            i_carry  = 1'($urandom);
            i_odd    = 1'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- Program counter and branch unit that consumes the latched ALU flags (zero, carry, odd).
- Sits directly downstream of the ALU flag registers and upstream of the memory address path.
- Increments, evaluates conditional jumps/calls against the flags, and keeps a small hardware return-address stack for CALL/RET.
- Driven by the instruction sequencer's control word, gated by the global clock enable.

Parameters:
ADDR_WIDTH, 16, width of program counter and jump target
STACK_DEPTH, 4, number of return-address stack entries (>=1)
DEPTH_WIDTH, 3, width of o_depth; must hold values 0..STACK_DEPTH

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
clk_en  input  1  global clock enable; no state changes when low
i_inc  input  1  increment PC when no transfer is taken
i_jump  input  1  conditional jump request
i_call  input  1  conditional call request
i_ret  input  1  unconditional return request
i_cond  input  3  condition select for jump/call
i_target  input  ADDR_WIDTH  jump/call destination
i_zero  input  1  ALU zero flag
i_carry  input  1  ALU carry flag
i_odd  input  1  ALU odd flag
o_pc  output  ADDR_WIDTH  current program counter
o_taken  output  1  registered: transfer taken on previous enabled edge
o_depth  output  DEPTH_WIDTH  current stack occupancy
o_overflow  output  1  sticky: CALL attempted with stack full
o_underflow  output  1  sticky: RET attempted with stack empty

Behaviour:
- Single clock domain; reset is synchronous and active-high.
- Reset values:
  - o_pc=0, o_taken=0, o_depth=0, o_overflow=0, o_underflow=0.
  - Stack contents are don't-care.
  - rst wins over clk_en and all requests.
- When clk_en=0: all registers hold, including o_taken.
- i_cond encoding, evaluated combinationally from the current flag inputs:
  - 0 always
  - 1 Z
  - 2 !Z
  - 3 C
  - 4 !C
  - 5 odd
  - 6 !odd
  - 7 never
- Request priority per enabled edge: i_ret > i_call > i_jump; lower-priority requests are ignored that cycle.
- RET:
  - Depth>0: pc <= top entry, depth-1, taken.
  - Depth==0: pc <= pc + i_inc, o_underflow <= 1, not taken.
- CALL, condition true:
  - Depth<STACK_DEPTH: push current o_pc (sequencer has already advanced past operands), pc <= i_target, depth+1, taken.
  - Stack full: no push, pc <= pc + i_inc, o_overflow <= 1, not taken.
- CALL, condition false: pc <= pc + i_inc, not taken.
- JUMP, condition true: pc <= i_target, taken. Condition false: pc <= pc + i_inc.
- No request: pc <= pc + i_inc.
- Increment is modulo 2^ADDR_WIDTH (all-ones + 1 = 0, no flag).
- o_taken is a one-cycle registered pulse, updated on every enabled edge: 1 if a transfer occurred on that edge, else 0.
- Sticky flags clear only on rst.
- Stack is LIFO, implemented as a register array indexed by depth (push writes entry[depth], pop reads entry[depth-1]).
- Flags are sampled on the same edge as the request. Flag changes on that edge from an ALU latch do not affect the decision; the old flag values apply.
- o_depth never exceeds STACK_DEPTH or goes below 0.

Test Plan:
- Reset then clk_en=1, i_inc=1 for 5 cycles -> o_pc 0,1,2,3,4,5. Preload pc=16'hFFFF via jump, inc -> o_pc=0, o_taken=0.
- i_jump=1, i_cond=1, i_target=16'h0040, i_zero=0, i_inc=1 at pc=7 -> o_pc=8, o_taken=0. Repeat with i_zero=1 -> o_pc=16'h0040, o_taken=1 for one cycle.
- Nested calls: at pc=10, call (cond 0) to 16'h0100; then call to 16'h0200 -> o_depth=2. RET -> o_pc=16'h0100. RET -> o_pc=10, o_depth=0.
- Five unconditional calls with STACK_DEPTH=4 -> fifth leaves o_pc at pc+i_inc, o_depth=4, o_overflow=1 and stays 1. RET x5 -> fifth sets o_underflow=1, o_depth=0.
- i_ret, i_call and i_jump all asserted at depth 1 with top=16'h0033 -> o_pc=16'h0033, o_depth=0 (RET wins). clk_en=0 with i_inc=1 -> o_pc, o_taken unchanged.
- Mid-sequence rst=1 with clk_en=0 at depth 3, o_overflow=1 -> next edge all outputs zero. rst with i_call asserted -> o_pc=0, o_depth=0.
